// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmit FSM states, error codes, command bytes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ps2_host_tx_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for the PS/2 clock/data pins plus a falling-edge pulse on clock.
// Latency: 2 cycles pin-to-sync, fall pulse valid in the cycle clk_sync first reads 0.
// Backpressure: none; free-running.
module ps2_host_tx_line_sync (
    input  logic clock,
    input  logic resetn,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_sync_d;

    // Idle PS/2 lines are high, so reset to 1 to avoid a false fall after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            clk_sync_d <= 1'b1;
            data_meta  <= 1'b1;
            data_sync  <= 1'b1;
        end else begin
            clk_meta   <= clk_in;
            clk_sync   <= clk_meta;
            clk_sync_d <= clk_sync;
            data_meta  <= data_in;
            data_sync  <= data_meta;
        end
    end

    assign clk_fall = clk_sync_d & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK check.
// Latency: INHIBIT_CYCLES + 1 before device clocking; pin drive follows each device fall by 3-4 cycles.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, watchdog aborts a stalled device.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_host_tx_line_sync u_line_sync (
        .clock     (clock),
        .resetn    (resetn),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       edge_cnt, edge_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             parity, parity_nxt;
    logic [1:0]       err_q, err_nxt;
    logic             wd_active;
    logic             wd_expired;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            err_q    <= ERR_OK;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            shreg    <= shreg_nxt;
            parity   <= parity_nxt;
            err_q    <= err_nxt;
        end
    end

    assign wd_active  = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY) ||
                        (state == ST_STOP_ACK) || (state == ST_WAIT_IDLE);
    // A fall in the expiry cycle counts as progress and wins over the timeout.
    assign wd_expired = wd_active && !clk_fall && (cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + 1'b1;
        edge_cnt_nxt = edge_cnt;
        shreg_nxt    = shreg;
        parity_nxt   = parity;
        err_nxt      = err_q;
        tx_ready     = 1'b0;
        tx_done      = 1'b0;
        tx_error     = 1'b0;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                cnt_nxt  = '0;
                if (tx_valid) begin
                    shreg_nxt  = tx_data;
                    parity_nxt = ~^tx_data;
                    err_nxt    = ERR_OK;
                    state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt == INHIBIT_LAST) state_nxt = ST_RTS;
            end
            ST_RTS: begin
                ps2_clk_oe   = 1'b1;
                ps2_data_oe  = 1'b1;
                edge_cnt_nxt = '0;
                state_nxt    = ST_START;
            end
            ST_START: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    edge_cnt_nxt = 4'd1;
                    state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                ps2_data_oe = ~shreg[0];
                if (clk_fall) begin
                    edge_cnt_nxt = edge_cnt + 1'b1;
                    if (edge_cnt == 4'd8) state_nxt = ST_PARITY;
                    else                  shreg_nxt = {1'b0, shreg[7:1]};
                end
            end
            ST_PARITY: begin
                ps2_data_oe = ~parity;
                if (clk_fall) begin
                    edge_cnt_nxt = edge_cnt + 1'b1;
                    state_nxt    = ST_STOP_ACK;
                end
            end
            // Data released as the stop bit; the next fall carries the device ACK.
            ST_STOP_ACK: begin
                if (clk_fall) begin
                    edge_cnt_nxt = edge_cnt + 1'b1;
                    if (!data_sync) begin
                        state_nxt = ST_WAIT_IDLE;
                    end else begin
                        err_nxt   = ERR_NOACK;
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                tx_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                tx_error  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (wd_expired) begin
            err_nxt   = ERR_TIMEOUT;
            state_nxt = ST_ERROR;
        end

        if ((state_nxt != state) || (wd_active && clk_fall)) cnt_nxt = '0;
    end

    assign tx_busy  = ~tx_ready;
    assign err_code = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model clocking at a 40-cycle period.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_busy, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       bfm_clk, bfm_data;
    wire        ps2_clk_in  = bfm_clk  & ~ps2_clk_oe;
    wire        ps2_data_in = bfm_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor: pulse counts, timestamps and busy-window bookkeeping.
    int         done_cnt = 0, err_cnt = 0, start_cnt = 0;
    int         err_cyc = 0, start_cyc = 0, doe_chg_cyc = 0;
    int         inhib_run = 0, inhib_last = 0;
    int         busy_viol = 0, busy_mis = 0;
    logic [1:0] err_oe = 2'b00, err_code_at = 2'b00, oe = 2'b00, prev_oe = 2'b00;
    logic       err_ready = 1'b0, ready_after_err = 1'b0;
    logic       prev_ready = 1'b1, prev_err = 1'b0, in_xfer = 1'b0;

    always @(negedge clock) begin
        if (!resetn) in_xfer = 1'b0;
        if (in_xfer && tx_ready) busy_viol++;
        if (tx_busy !== ~tx_ready) busy_mis++;
        if (prev_ready && !tx_ready) in_xfer = 1'b1;
        if (tx_done || tx_error) in_xfer = 1'b0;
        if (prev_err) ready_after_err = tx_ready;
        if (tx_error) begin
            err_cnt++;
            err_cyc     = cyc;
            err_oe      = {ps2_clk_oe, ps2_data_oe};
            err_ready   = tx_ready;
            err_code_at = err_code;
        end
        if (tx_done) done_cnt++;
        oe = {ps2_clk_oe, ps2_data_oe};
        if (oe == 2'b10) begin
            if (prev_oe != 2'b10) begin
                start_cnt++;
                inhib_run = 0;
            end
            inhib_run++;
        end
        if (oe == 2'b11 && prev_oe == 2'b10) inhib_last = inhib_run;
        if (oe == 2'b01 && prev_oe == 2'b11) start_cyc = cyc;
        if (ps2_data_oe != prev_oe[0]) doe_chg_cyc = cyc;
        prev_oe    = oe;
        prev_ready = tx_ready;
        prev_err   = tx_error;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_before_send", {31'b0, ok}, 1);
        @(posedge clock); #1;
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
    endtask

    // Device model: waits for RTS, then issues nfalls clock pulses; captures data before each rise.
    task automatic dev_run(input int nfalls, input bit ack, input bit pulse_mid,
                           output logic [9:0] bits, output bit rts_ok);
        bits   = '0;
        rts_ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (!ps2_clk_oe && ps2_data_oe) begin
                rts_ok = 1'b1;
                break;
            end
        end
        if (rts_ok) begin
            for (int k = 1; k <= nfalls; k++) begin
                @(posedge clock); #1;
                bfm_clk = 1'b0;
                if (pulse_mid && k == 5) begin
                    tx_data  = 8'h33;
                    tx_valid = 1'b1;
                    @(posedge clock); #1;
                    tx_valid = 1'b0;
                    repeat (17) @(posedge clock);
                end else begin
                    repeat (18) @(posedge clock);
                end
                @(negedge clock);
                if (k <= 10) bits[k-1] = ps2_data_in;
                @(posedge clock); #1;
                bfm_clk = 1'b1;
                if (k == 11) bfm_data = 1'b1;
                if (k == 10 && ack) begin
                    repeat (10) @(posedge clock); #1;
                    bfm_data = 1'b0;
                    repeat (9) @(posedge clock);
                end else begin
                    repeat (19) @(posedge clock);
                end
            end
        end
        bfm_data = 1'b1;
    endtask

    task automatic wait_end(input int d0, input int e0);
        bit ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        check("end_wait", {31'b0, ok}, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nfalls;
        bit         ack;
        bit         pulse_mid;
        int         tmode;      // 0 none, 1 timeout from START entry, 2 from last data drive change
        logic [9:0] exp_bits;   // {stop, parity, b7..b0} as seen on the line
        bit         exp_done;
        logic [1:0] exp_code;
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] cap;
    bit         rts_ok;
    int         d0, e0, s0, nb;
    logic [31:0] mask;

    initial begin
        vecs[0] = '{CMD_SET_LED, 11, 1'b1, 1'b1, 0, 10'h3ED, 1'b1, ERR_OK};
        vecs[1] = '{8'h01,       11, 1'b1, 1'b0, 0, 10'h201, 1'b1, ERR_OK};
        vecs[2] = '{8'hA5,       11, 1'b0, 1'b0, 0, 10'h3A5, 1'b0, ERR_NOACK};
        vecs[3] = '{8'h08,        4, 1'b0, 1'b0, 2, 10'h008, 1'b0, ERR_TIMEOUT};
        vecs[4] = '{8'h5A,        0, 1'b0, 1'b0, 1, 10'h000, 1'b0, ERR_TIMEOUT};

        resetn   = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        bfm_clk  = 1'b1;
        bfm_data = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_clk_oe",   {31'b0, ps2_clk_oe},  0);
        check("rst_data_oe",  {31'b0, ps2_data_oe}, 0);
        check("rst_ready",    {31'b0, tx_ready},    1);
        check("rst_busy",     {31'b0, tx_busy},     0);
        check("rst_done",     {31'b0, tx_done},     0);
        check("rst_error",    {31'b0, tx_error},    0);
        check("rst_err_code", {30'b0, err_code},    {30'b0, ERR_OK});
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clock);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            s0 = start_cnt;
            send(vecs[v].data);
            dev_run(vecs[v].nfalls, vecs[v].ack, vecs[v].pulse_mid, cap, rts_ok);
            check("rts_seen", {31'b0, rts_ok}, 1);
            nb   = (vecs[v].nfalls > 10) ? 10 : vecs[v].nfalls;
            mask = (32'd1 << nb) - 32'd1;
            if (nb > 0) check("line_bits", {22'b0, cap} & mask, {22'b0, vecs[v].exp_bits} & mask);
            wait_end(d0, e0);
            repeat (2) @(negedge clock);
            check("done_pulses",  done_cnt - d0, {31'b0, vecs[v].exp_done});
            check("error_pulses", err_cnt - e0,  {31'b0, ~vecs[v].exp_done});
            check("err_code",     {30'b0, err_code}, {30'b0, vecs[v].exp_code});
            check("oe_released",  {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
            check("ready_after",  {31'b0, tx_ready}, 1);
            check("inhibit_len",  inhib_last, 20);
            if (!vecs[v].exp_done) begin
                check("err_pulse_oe",    {30'b0, err_oe}, 0);
                check("err_pulse_ready", {31'b0, err_ready}, 0);
                check("ready_next_err",  {31'b0, ready_after_err}, 1);
                check("err_code_pulse",  {30'b0, err_code_at}, {30'b0, vecs[v].exp_code});
            end
            if (vecs[v].tmode == 1) check("timeout_from_start", err_cyc - start_cyc, 200);
            if (vecs[v].tmode == 2) check("timeout_from_fall4", err_cyc - doe_chg_cyc, 200);
            repeat (30) @(negedge clock);
            check("starts_per_xfer", start_cnt - s0, 1);
        end

        // Asynchronous reset while the host is driving a data bit.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h00);
        dev_run(3, 1'b0, 1'b0, cap, rts_ok);
        check("rts_seen_rst", {31'b0, rts_ok}, 1);
        check("pre_rst_data_oe", {31'b0, ps2_data_oe}, 1);
        check("pre_rst_ready",   {31'b0, tx_ready},    0);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1;
        check("async_rst_oe",    {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
        check("async_rst_ready", {31'b0, tx_ready}, 1);
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_ready", {31'b0, tx_ready}, 1);
        check("post_rst_busy",  {31'b0, tx_busy},  0);
        check("post_rst_code",  {30'b0, err_code}, {30'b0, ERR_OK});
        check("post_rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        check("ready_low_in_xfer", busy_viol, 0);
        check("busy_is_not_ready", busy_mis, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
